door_lock_controller: RTL

//  Consumes access verdicts (grant/deny + user ID) from the keypad/password-check path via a valid/ready handshake.

---
 rtl/door_lock_pkg.sv | 20 ++
 rtl/lock_timer.sv | 23 ++
 rtl/door_lock_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/door_lock_pkg.sv
// Shared types and constants for the door lock controller.
package door_lock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    OPEN     = 2'd2,
    LOCKOUT  = 2'd3
  } door_state_t;

  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] NO_USER_ID = 4'd0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by all timed states; holds at zero once expired.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   count <= '0;
    else if (load)                  count <= load_val;
    else if (run && count != '0)    count <= count - W'(1);
  end

  assign expire = run && (count == '0);

endmodule

// File: rtl/door_lock_controller.sv
// Door strike / sensor supervisor fed by access verdicts over valid/ready.
// Optional build macro: FORCED_ENTRY_ALARM_EN (door opening while locked raises a sticky alarm).
module door_lock_controller
  import door_lock_pkg::*;
#(
  parameter int UNLOCK_CYCLES  = 50_000_000,
  parameter int AJAR_CYCLES    = 500_000_000,
  parameter int LOCKOUT_CYCLES = 1_500_000_000,
  parameter int MAX_FAILS      = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_grant,
  input  logic [ID_W-1:0]                  req_id,
  input  logic                             door_open,
  output logic                             unlock,
  output logic                             alarm,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic [ID_W-1:0]                  last_id
);

  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = max3(UNLOCK_CYCLES, AJAR_CYCLES, LOCKOUT_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  door_state_t      state, state_nxt;
  logic [FC_W-1:0]  fail_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic             tmr_load, tmr_run, tmr_expire, ajar, accept;
  logic [TMR_W-1:0] tmr_val;

  assign accept  = req_valid && req_ready;
  assign tmr_run = (state != IDLE);

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fail_count <= '0;
      last_id    <= NO_USER_ID;
    end else begin
      state      <= state_nxt;
      fail_count <= fail_nxt;
      last_id    <= id_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fail_nxt   = fail_count;
    id_nxt     = last_id;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    req_ready  = (state == IDLE);
    unlock     = (state == UNLOCKED);
    locked_out = (state == LOCKOUT);
    case (state)
      IDLE: if (req_valid) begin
        if (req_grant) begin
          state_nxt = UNLOCKED;
          id_nxt    = req_id;
          fail_nxt  = '0;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(UNLOCK_CYCLES - 1);
        end else begin
          if (fail_count != FC_W'(MAX_FAILS)) fail_nxt = fail_count + FC_W'(1);
          if (fail_nxt == FC_W'(MAX_FAILS)) begin
            state_nxt = LOCKOUT;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(LOCKOUT_CYCLES - 1);
          end
        end
      end
      // Door opening takes priority over a simultaneous unlock-window expiry.
      UNLOCKED: if (door_open) begin
        state_nxt = OPEN;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(AJAR_CYCLES - 1);
      end else if (tmr_expire) begin
        state_nxt = IDLE;
      end
      OPEN: if (!door_open) state_nxt = IDLE;
      LOCKOUT: if (tmr_expire) begin
        state_nxt = IDLE;
        fail_nxt  = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timer parks at zero in OPEN, so the ajar alarm holds until the door closes.
  assign ajar = (state == OPEN) && tmr_expire;

`ifdef FORCED_ENTRY_ALARM_EN
  logic forced;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 forced <= 1'b0;
    else if (accept && req_grant) forced <= 1'b0;
    else if (door_open && (state == IDLE || state == LOCKOUT)) forced <= 1'b1;
  end

  assign alarm = ajar | forced;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign alarm = ajar;
`endif

endmodule
